id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  - ID/EX pipeline register of the RV32I 5-stage core; sits directly downstream of the register file.
//  - Captures RD1/RD2, immediate, PC and control bundle at decode; presents them to execute one cycle later.
//  - Contains load-use hazard detection (stall + bubble), branch flush, and WB->ID write-through bypass.
//  - The bypass covers the regfile posedge-write / same-cycle-read gap.
// PARAMETERS
//  - XLEN       32  datapath width
//  - CTRL_W     16  width of decoded control bundle
//  - MEMRD_BIT  3   bit index of mem_read within ctrl bundle
// PORTS
//  - clk          in   1       rising-edge clock
//  - rst          in   1       synchronous reset, active-high
//  - valid_d      in   1       decode slot holds a real instruction
//  - instr_d      in   32      instruction in decode (rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0])
//  - pc_d         in   XLEN    PC of decode instruction
//  - pc_plus4_d   in   XLEN    PC+4 of decode instruction
//  - rd1_d        in   XLEN    register file RD1 (A1=rs1)
//  - rd2_d        in   XLEN    register file RD2 (A2=rs2)
//  - imm_d        in   XLEN    sign-extended immediate
//  - ctrl_d       in   CTRL_W  decoded control bundle
//  - flush_e      in   1       branch/jump taken in EX; kill decode instruction
//  - wb_we        in   1       writeback enable (same as regfile WE3)
//  - wb_rd        in   5       writeback dest (same as regfile A3)
//  - wb_data      in   XLEN    writeback data (same as regfile WD3)
//  - stall_f      out  1       hold PC
//  - stall_d      out  1       hold IF/ID register
//  - valid_e      out  1       EX slot valid
//  - rs1_e, rs2_e, rd_e  out  5 each  register indices for forwarding unit
//  - rd1_e, rd2_e        out  XLEN    operand values
//  - imm_e, pc_e, pc_plus4_e  out  XLEN
//  - ctrl_e       out  CTRL_W
// BEHAVIOUR
//  - All EX outputs registered; latency 1 cycle D->E. stall_f/stall_d combinational.
//  - Reset: every registered output = 0 (valid_e=0, ctrl_e=0). Reset mid-stall drops the in-flight bubble.
//  - Register uses by opcode:
//    - uses_rs1 = 0 for LUI, AUIPC, JAL; 1 otherwise.
//    - uses_rs2 = 1 only for OP (R-type), STORE, BRANCH.
//  - hazard = valid_d & valid_e & ctrl_e[MEMRD_BIT] & rd_e!=0 & ((uses_rs1 & rd_e==rs1_d) | (uses_rs2 & rd_e==rs2_d)).
//  - stall_f = stall_d = hazard & ~flush_e.
//  - Per-cycle priority:
//    1. rst: all zero.
//    2. flush_e: bubble (valid_e=0, ctrl_e=0); data fields don't-care but driven 0.
//    3. hazard: bubble, identical to flush; D instruction re-presented next cycle.
//    4. else: capture D fields; valid_e=valid_d; ctrl_e=valid_d?ctrl_d:0.
//  - Operand select for rd1_e (rd2_e symmetric on rs2):
//    - rs1_d==0 -> 0 (x0 hard-wired regardless of regfile contents).
//    - else if wb_we & wb_rd==rs1_d -> wb_data.
//    - else rd1_d.
//  - wb_rd==0 never bypasses. A hazard lasts exactly one cycle (bubble clears ctrl_e mem_read).
//  - Back-to-back loads each produce their own single stall.
// CONFIGURATION
//  - Macro ID_EX_PERF_CNT_EN.
//  - Defined: adds outputs stall_cnt and flush_cnt (32 each).
//    - Cleared on rst.
//    - stall_cnt +1 each cycle stall_d=1; flush_cnt +1 each cycle flush_e=1.
//    - Both wrap at 2^32-1 -> 0.
//  - Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - riscv_pkg: opcode localparams (OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_R 0110011,
//    OP_STORE 0100011, OP_BRANCH 1100011), CTRL_W, MEMRD_BIT, XLEN.
//  - Sub-module hazard_unit: combinational uses_rs1/uses_rs2 decode plus hazard/stall equations.
//  - Pipeline registers and bypass muxes live in id_ex_stage.
// TESTING
//  1. Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, stall_f=stall_d=0.
//  2. Pass-through: add x3,x2,x9, rd1_d=5, rd2_d=1, pc_d=0x100 -> next cycle valid_e=1, rd1_e=5, rd2_e=1,
//     rd_e=3, pc_e=0x100.
//  3. Load-use: lw x7,0(x2) in EX, add x8,x7,x3 in D -> stall_f=stall_d=1 for 1 cycle, EX bubble
//     (valid_e=0, ctrl_e=0), then add captured.
//  4. Bypass: wb_we=1, wb_rd=2, wb_data=0xDEADBEEF, rs1_d=2, rd1_d=5 -> rd1_e=0xDEADBEEF.
//     - Same with wb_rd=0 and rs1_d=0 -> rd1_e=0.
//  5. Flush+hazard same cycle: load-use condition with flush_e=1 -> stall=0, bubble in EX.
//     - lui x5 after lw x5: no stall.
//  6. ID_EX_PERF_CNT_EN: run test 3 twice plus 3 flush cycles -> stall_cnt=2, flush_cnt=3.
//     - Preload 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants, EX-stage register bundle and operand bypass helper.
// Latency: none (types and pure functions only).
// Backpressure: none.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int CTRL_W    = 16;
  localparam int MEMRD_BIT = 3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Everything the EX stage sees, held in one register so a bubble is a single '0 load.
  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } ex_bundle_t;

  // x0 reads as zero; a same-cycle writeback to the source register wins over the
  // stale regfile read, since the regfile only commits the write on the next edge.
  function automatic logic [XLEN-1:0] bypass_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_val,
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdat
  );
    logic [XLEN-1:0] res;
    if (rs == 5'd0)
      res = '0;
    else if (we && (wrd == rs))
      res = wdat;
    else
      res = rf_val;
    return res;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection: decodes which sources the D instruction reads and compares to a load in EX.
// Latency: purely combinational.
// Backpressure: produces stall_f/stall_d; a branch flush in EX overrides the stall.
module hazard_unit
  import riscv_pkg::*;
(
  input  logic       valid_d,
  input  logic [6:0] opcode_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       valid_e,
  input  logic       mem_read_e,
  input  logic [4:0] rd_e,
  input  logic       flush_e,
  output logic       hazard,
  output logic       stall_f,
  output logic       stall_d
);

  logic uses_rs1;
  logic uses_rs2;

  // Source-register usage by opcode; U-type and JAL carry immediate bits in the rs1 field.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    if ((opcode_d == OP_LUI) || (opcode_d == OP_AUIPC) || (opcode_d == OP_JAL))
      uses_rs1 = 1'b0;
    if ((opcode_d == OP_R) || (opcode_d == OP_STORE) || (opcode_d == OP_BRANCH))
      uses_rs2 = 1'b1;
  end

  // Hazard only against a real load writing a non-x0 register; a flush kills D so no stall is needed.
  always_comb begin
    hazard  = valid_d & valid_e & mem_read_e & (rd_e != 5'd0) &
              ((uses_rs1 & (rd_e == rs1_d)) | (uses_rs2 & (rd_e == rs2_d)));
    stall_f = hazard & ~flush_e;
    stall_d = hazard & ~flush_e;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush bubble and WB->ID bypass (optional ID_EX_PERF_CNT_EN counters).
// Latency: one cycle D->E for all EX outputs; stall_f/stall_d combinational.
// Backpressure: load-use hazard holds PC and IF/ID for one cycle while a bubble enters EX.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              flush_e,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_f,
  output logic              stall_d,
  output logic              valid_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [CTRL_W-1:0] ctrl_e
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_d;
  logic       hazard;
  logic       unused_instr_bits;
  ex_bundle_t ex_d;
  ex_bundle_t ex_q;

  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];
  assign rd_d  = instr_d[11:7];
  assign unused_instr_bits = ^{instr_d[31:25], instr_d[14:12]};

  hazard_unit u_hazard (
    .valid_d    (valid_d),
    .opcode_d   (instr_d[6:0]),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .valid_e    (ex_q.vld),
    .mem_read_e (ex_q.ctrl[MEMRD_BIT]),
    .rd_e       (ex_q.rd),
    .flush_e    (flush_e),
    .hazard     (hazard),
    .stall_f    (stall_f),
    .stall_d    (stall_d)
  );

  // Next EX contents from decode, with bypassed operands and control zeroed for empty slots.
  always_comb begin
    ex_d          = '0;
    ex_d.vld      = valid_d;
    ex_d.ctrl     = valid_d ? ctrl_d : '0;
    ex_d.rs1      = rs1_d;
    ex_d.rs2      = rs2_d;
    ex_d.rd       = rd_d;
    ex_d.rd1      = bypass_sel(rs1_d, rd1_d, wb_we, wb_rd, wb_data);
    ex_d.rd2      = bypass_sel(rs2_d, rd2_d, wb_we, wb_rd, wb_data);
    ex_d.imm      = imm_d;
    ex_d.pc       = pc_d;
    ex_d.pc_plus4 = pc_plus4_d;
  end

  // Pipeline register: reset, flush and load-use all insert an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst)
      ex_q <= '0;
    else if (flush_e || hazard)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign valid_e    = ex_q.vld;
  assign ctrl_e     = ex_q.ctrl;
  assign rs1_e      = ex_q.rs1;
  assign rs2_e      = ex_q.rs2;
  assign rd_e       = ex_q.rd;
  assign rd1_e      = ex_q.rd1;
  assign rd2_e      = ex_q.rd2;
  assign imm_e      = ex_q.imm;
  assign pc_e       = ex_q.pc;
  assign pc_plus4_e = ex_q.pc_plus4;

`ifdef ID_EX_PERF_CNT_EN
  // Stall and flush cycle counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d) stall_cnt <= stall_cnt + 32'd1;
      if (flush_e) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a regfile-level reference model predicts each cycle's EX contents and stalls.
// Latency: expectations are pushed at drive time and popped by an independent monitor.
// Backpressure: the driver re-presents the decode instruction whenever the model predicts a stall.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam logic [6:0]  OP_LOAD = 7'b0000011;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [15:0] C_LD    = 16'h0008;
  localparam logic [15:0] C_ALU   = 16'h0101;

  logic clk, rst, valid_d, flush_e, wb_we;
  logic [31:0] instr_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d, wb_data;
  logic [15:0] ctrl_d;
  logic [4:0]  wb_rd;
  logic stall_f, stall_d, valid_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [15:0] ctrl_e;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
    .flush_e(flush_e), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_f(stall_f), .stall_d(stall_d), .valid_e(valid_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .ctrl_e(ctrl_e)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] a, b, imm, pc, pc4;
  } ex_t;

  typedef struct {
    logic        chk_st;
    logic        st;
    ex_t         ex;
    logic [31:0] scnt, fcnt;
  } exp_t;

  exp_t        q[$];
  ex_t         m;
  logic [31:0] rf[32];
  logic [31:0] m_scnt, m_fcnt;
  logic        first_cycle, last_stall;
  int          total, bad;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'h2, rd, op};
  endfunction

  // Architectural value an instruction reading register r should see this cycle.
  function automatic logic [31:0] arch_val(input logic [4:0] r, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
    if (we && (wrd == r)) return wd;
    return rf[r];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one decode cycle and push what EX must look like after the next edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [15:0] c,
                      input logic fl, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic [31:0] pc);
    exp_t       e;
    logic [4:0] s1, s2;
    logic [6:0] op;
    logic       reads1, reads2, load_ex, hz;
    @(negedge clk);
    s1 = ins[19:15]; s2 = ins[24:20]; op = ins[6:0];
    rst = r; valid_d = v; instr_d = ins; ctrl_d = c; flush_e = fl;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    pc_d = pc; pc_plus4_d = pc + 32'd4; imm_d = $urandom;
    rd1_d = rf[s1]; rd2_d = rf[s2];
    reads1  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    reads2  = (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    load_ex = m.v && m.ctrl[MEMRD_BIT] && (m.rd != 5'd0);
    hz      = v && load_ex && ((reads1 && m.rd == s1) || (reads2 && m.rd == s2));
    e.chk_st = !first_cycle;
    e.st     = hz && !fl;
    if (r || fl || hz) begin
      m = '{v: 1'b0, ctrl: 16'h0, rs1: 5'h0, rs2: 5'h0, rd: 5'h0,
            a: 32'h0, b: 32'h0, imm: 32'h0, pc: 32'h0, pc4: 32'h0};
    end else begin
      m.v = v; m.ctrl = v ? c : 16'h0;
      m.rs1 = s1; m.rs2 = s2; m.rd = ins[11:7];
      m.a = arch_val(s1, we, wrd, wd); m.b = arch_val(s2, we, wrd, wd);
      m.imm = imm_d; m.pc = pc; m.pc4 = pc + 32'd4;
    end
    if (r) begin m_scnt = 0; m_fcnt = 0; end
    else begin
      if (e.st) m_scnt = m_scnt + 32'd1;
      if (fl)   m_fcnt = m_fcnt + 32'd1;
    end
    e.ex = m; e.scnt = m_scnt; e.fcnt = m_fcnt;
    q.push_back(e);
    if (we) rf[wrd] = wd;
    last_stall  = e.st;
    first_cycle = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins, input logic [15:0] c, input logic fl);
    step(1'b0, 1'b1, ins, c, fl, 1'b0, 5'd0, 32'h0, $urandom);
  endtask

  // Monitor: stalls checked late in the low phase, EX registers just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk_st) begin
          chk("stall_f", {31'h0, stall_f}, {31'h0, e.st});
          chk("stall_d", {31'h0, stall_d}, {31'h0, e.st});
        end
        @(posedge clk);
        #1;
        chk("valid_e", {31'h0, valid_e}, {31'h0, e.ex.v});
        chk("ctrl_e", {16'h0, ctrl_e}, {16'h0, e.ex.ctrl});
        chk("rs1_e", {27'h0, rs1_e}, {27'h0, e.ex.rs1});
        chk("rs2_e", {27'h0, rs2_e}, {27'h0, e.ex.rs2});
        chk("rd_e", {27'h0, rd_e}, {27'h0, e.ex.rd});
        chk("rd1_e", rd1_e, e.ex.a);
        chk("rd2_e", rd2_e, e.ex.b);
        chk("imm_e", imm_e, e.ex.imm);
        chk("pc_e", pc_e, e.ex.pc);
        chk("pc_plus4_e", pc_plus4_e, e.ex.pc4);
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e.scnt);
        chk("flush_cnt", flush_cnt, e.fcnt);
`endif
      end
    end
  end

  // Driver: directed cases from the block's scenarios, then constrained-random traffic.
  initial begin
    logic [31:0] p_ins, p_pc;
    logic [15:0] p_c;
    logic        p_v;
    logic [6:0]  ops[8];
    total = 0; bad = 0; first_cycle = 1'b1; last_stall = 1'b0;
    m_scnt = 0; m_fcnt = 0;
    m = '{v: 1'b0, ctrl: 16'h0, rs1: 5'h0, rs2: 5'h0, rd: 5'h0,
          a: 32'h0, b: 32'h0, imm: 32'h0, pc: 32'h0, pc4: 32'h0};
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_STORE, OP_BRANCH, OP_LOAD, OP_IMM};

    // reset with random inputs
    repeat (2) step(1'b1, 1'($urandom), $urandom, 16'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom), $urandom, $urandom);
    // pass-through add x3,x2,x9
    rf[2] = 32'd5; rf[9] = 32'd1;
    step(1'b0, 1'b1, enc(OP_R, 5'd3, 5'd2, 5'd9), C_ALU, 1'b0, 1'b0, 5'd0, 32'h0, 32'h100);
    // load-use, twice, D re-presented after the stall
    repeat (2) begin
      run(enc(OP_LOAD, 5'd7, 5'd2, 5'd0), C_LD, 1'b0);
      run(enc(OP_R, 5'd8, 5'd7, 5'd3), C_ALU, 1'b0);
      run(enc(OP_R, 5'd8, 5'd7, 5'd3), C_ALU, 1'b0);
    end
    // bypass from writeback, then x0 with writeback to x0 and garbage regfile x0
    rf[2] = 32'd5; rf[0] = 32'h1234_5678;
    step(1'b0, 1'b1, enc(OP_R, 5'd4, 5'd2, 5'd5), C_ALU, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, $urandom);
    step(1'b0, 1'b1, enc(OP_R, 5'd4, 5'd0, 5'd5), C_ALU, 1'b0, 1'b1, 5'd0, 32'hCAFEF00D, $urandom);
    // flush on top of a load-use
    run(enc(OP_LOAD, 5'd7, 5'd2, 5'd0), C_LD, 1'b0);
    run(enc(OP_R, 5'd8, 5'd7, 5'd3), C_ALU, 1'b1);
    // lui after load to same register, load to x0, store data dependency
    run(enc(OP_LOAD, 5'd5, 5'd2, 5'd0), C_LD, 1'b0);
    run(enc(OP_LUI, 5'd5, 5'd5, 5'd5), C_ALU, 1'b0);
    run(enc(OP_LOAD, 5'd0, 5'd2, 5'd0), C_LD, 1'b0);
    run(enc(OP_R, 5'd1, 5'd0, 5'd0), C_ALU, 1'b0);
    run(enc(OP_LOAD, 5'd6, 5'd2, 5'd0), C_LD, 1'b0);
    run(enc(OP_STORE, 5'd0, 5'd1, 5'd6), C_ALU, 1'b0);
    run(enc(OP_STORE, 5'd0, 5'd1, 5'd6), C_ALU, 1'b0);
    // back-to-back loads
    run(enc(OP_LOAD, 5'd1, 5'd2, 5'd0), C_LD, 1'b0);
    run(enc(OP_LOAD, 5'd3, 5'd1, 5'd0), C_LD, 1'b0);
    run(enc(OP_LOAD, 5'd3, 5'd1, 5'd0), C_LD, 1'b0);
    run(enc(OP_R, 5'd4, 5'd3, 5'd3), C_ALU, 1'b0);
    run(enc(OP_R, 5'd4, 5'd3, 5'd3), C_ALU, 1'b0);
    // three flush cycles, then reset in the middle of a stall
    repeat (3) run(enc(OP_IMM, 5'd9, 5'd1, 5'd0), C_ALU, 1'b1);
    run(enc(OP_LOAD, 5'd6, 5'd2, 5'd0), C_LD, 1'b0);
    run(enc(OP_R, 5'd7, 5'd6, 5'd1), C_ALU, 1'b0);
    step(1'b1, 1'b1, enc(OP_R, 5'd7, 5'd6, 5'd1), C_ALU, 1'b0, 1'b0, 5'd0, 32'h0, 32'h40);
    step(1'b0, 1'b1, enc(OP_R, 5'd7, 5'd6, 5'd1), C_ALU, 1'b0, 1'b0, 5'd0, 32'h0, 32'h40);

    // random traffic over a small register window so hazards and bypasses are frequent
    p_ins = 32'h0; p_pc = 32'h0; p_c = 16'h0; p_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        p_ins = enc(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        p_ins[31:25] = 7'($urandom_range(0, 127));
        p_c   = 16'($urandom);
        if (p_ins[6:0] == OP_LOAD) p_c[MEMRD_BIT] = 1'b1;
        p_v   = ($urandom_range(0, 7) != 0);
        p_pc  = $urandom;
      end
      step(($urandom_range(0, 49) == 0), p_v, p_ins, p_c, ($urandom_range(0, 7) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom, p_pc);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
